// File: rtl/mont_final_sub.sv
// rtl/mont_final_sub.sv - Montgomery final conditional subtraction, CHUNK bits per cycle
// Rotates T and M one slice per SUB cycle so the subtractor always reads the low slice.
module mont_final_sub #(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH:0]   in_t,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        SEL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    t_q, t_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [CHUNK:0]    slice;
    logic              ge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            t_q      <= '0;
            m_q      <= '0;
            diff_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            m_q      <= m_d;
            diff_q   <= diff_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SUB;
            SUB:     if (idx_q == LAST_IDX) state_d = SEL;
            SEL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Borrow out of the slice lands in the extra top bit of the CHUNK+1 wide difference.
    assign slice = {1'b0, t_q[CHUNK-1:0]} - {1'b0, m_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
    assign ge    = t_q[WIDTH] | ~borrow_q;

    always_comb begin
        t_d      = t_q;
        m_d      = m_q;
        diff_d   = diff_q;
        result_d = result_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    t_d      = in_t;
                    m_d      = in_m;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            SUB: begin
                // After NCHUNK rotations T and M are back in place and diff is fully assembled.
                t_d      = {t_q[WIDTH], t_q[CHUNK-1:0], t_q[WIDTH-1:CHUNK]};
                m_d      = {m_q[CHUNK-1:0], m_q[WIDTH-1:CHUNK]};
                diff_d   = {slice[CHUNK-1:0], diff_q[WIDTH-1:CHUNK]};
                borrow_d = slice[CHUNK];
                idx_d    = idx_q + 1'b1;
            end
            SEL: begin
                result_d = ge ? diff_q : t_q[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
